// File: rtl/tile_flush_scheduler.sv
// Tile write-back sequencer: ping-pongs two tile RAM banks between the rasterizer and the
// tile writer, walks tiles in raster order and reports frame completion after the flush.
module tile_flush_scheduler #(
    parameter int unsigned TILE_W_BYTES   = 64,
    parameter int unsigned TILE_ROWS_LOG2 = 5,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        gpu_clk,
    input  logic        gpu_rst,
    input  logic [31:0] frame_base,
    input  logic [15:0] frame_stride,
    input  logic [7:0]  tiles_x,
    input  logic [7:0]  tiles_y,
    input  logic        frame_start,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        raster_bank,
    input  logic        raster_tile_valid,
    output logic        raster_tile_ready,
    output logic        wr_start,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_stride,
    output logic        wr_bank,
    input  logic        wr_reading,
    input  logic        wr_flushed
);

    typedef enum logic [2:0] {StIdle, StReady, StIssue, StWait, StFlush, StDone} state_e;

    state_e           state_q, state_d;
    logic [15:0]      stride_q, stride_d;
    logic [7:0]       tiles_x_q, tiles_x_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       ty_q, ty_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] accepted_q, accepted_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [31:0]      row_base_q, row_base_d;
    logic [31:0]      col_off_q, col_off_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             raster_bank_q, raster_bank_d;
    logic             drain_bank_q, drain_bank_d;
    logic             guard_q, guard_d;

    logic             accept;
    logic [CNT_W-1:0] frame_total;
    logic [31:0]      row_step;

    assign frame_total = CNT_W'(tiles_x) * CNT_W'(tiles_y);
    // Stride is zero-extended before shifting so large strides are not truncated.
    assign row_step    = 32'(stride_q) << TILE_ROWS_LOG2;

    assign frame_busy        = (state_q != StIdle);
    assign frame_done        = (state_q == StDone);
    assign wr_start          = (state_q == StIssue);
    assign wr_addr           = wr_start ? (row_base_q + col_off_q) : 32'h0;
    assign wr_stride         = stride_q;
    assign wr_bank           = drain_bank_q;
    assign raster_bank       = raster_bank_q;
    assign raster_tile_ready = frame_busy && !bank_full_q[raster_bank_q] &&
                               (accepted_q < total_q);
    assign accept            = raster_tile_valid && raster_tile_ready;

    always_comb begin
        state_d       = state_q;
        stride_d      = stride_q;
        tiles_x_d     = tiles_x_q;
        tx_d          = tx_q;
        ty_d          = ty_q;
        total_d       = total_q;
        accepted_d    = accepted_q;
        issued_d      = issued_q;
        row_base_d    = row_base_q;
        col_off_d     = col_off_q;
        bank_full_d   = bank_full_q;
        raster_bank_d = raster_bank_q;
        drain_bank_d  = drain_bank_q;
        guard_d       = guard_q;

        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    stride_d   = frame_stride;
                    tiles_x_d  = tiles_x;
                    total_d    = frame_total;
                    accepted_d = '0;
                    issued_d   = '0;
                    tx_d       = 8'h0;
                    ty_d       = 8'h0;
                    row_base_d = frame_base;
                    col_off_d  = 32'h0;
                    state_d    = (frame_total == '0) ? StDone : StReady;
                end
            end
            StReady: begin
                if (bank_full_q[drain_bank_q]) begin
                    state_d = StIssue;
                end else if (issued_q == total_q) begin
                    state_d = StFlush;
                end
            end
            StIssue: begin
                guard_d = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                // wr_reading only rises the cycle after wr_start, so skip the first cycle.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!wr_reading) begin
                    bank_full_d[drain_bank_q] = 1'b0;
                    drain_bank_d              = ~drain_bank_q;
                    issued_d                  = issued_q + 1'b1;
                    if (tx_q == tiles_x_q - 8'd1) begin
                        tx_d       = 8'h0;
                        ty_d       = ty_q + 8'd1;
                        col_off_d  = 32'h0;
                        row_base_d = row_base_q + row_step;
                    end else begin
                        tx_d      = tx_q + 8'd1;
                        col_off_d = col_off_q + 32'(TILE_W_BYTES);
                    end
                    state_d = StReady;
                end
            end
            StFlush: begin
                if (wr_flushed) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Accept and drain always hit opposite banks, so both updates compose.
        if (accept) begin
            bank_full_d[raster_bank_q] = 1'b1;
            raster_bank_d              = ~raster_bank_q;
            accepted_d                 = accepted_q + 1'b1;
        end
    end

    always_ff @(posedge gpu_clk or posedge gpu_rst) begin
        if (gpu_rst) begin
            state_q       <= StIdle;
            stride_q      <= 16'h0;
            tiles_x_q     <= 8'h0;
            tx_q          <= 8'h0;
            ty_q          <= 8'h0;
            total_q       <= '0;
            accepted_q    <= '0;
            issued_q      <= '0;
            row_base_q    <= 32'h0;
            col_off_q     <= 32'h0;
            bank_full_q   <= 2'b00;
            raster_bank_q <= 1'b0;
            drain_bank_q  <= 1'b0;
            guard_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            stride_q      <= stride_d;
            tiles_x_q     <= tiles_x_d;
            tx_q          <= tx_d;
            ty_q          <= ty_d;
            total_q       <= total_d;
            accepted_q    <= accepted_d;
            issued_q      <= issued_d;
            row_base_q    <= row_base_d;
            col_off_q     <= col_off_d;
            bank_full_q   <= bank_full_d;
            raster_bank_q <= raster_bank_d;
            drain_bank_q  <= drain_bank_d;
            guard_q       <= guard_d;
        end
    end

endmodule

// File: tb/tb_tile_flush_scheduler.sv
// Self-checking bench for tile_flush_scheduler: writer model, wr_start scoreboard and
// one task per scenario.
module tb_tile_flush_scheduler;

    logic        gpu_clk = 1'b0;
    logic        gpu_rst;
    logic [31:0] frame_base;
    logic [15:0] frame_stride;
    logic [7:0]  tiles_x;
    logic [7:0]  tiles_y;
    logic        frame_start;
    logic        frame_busy;
    logic        frame_done;
    logic        raster_bank;
    logic        raster_tile_valid;
    logic        raster_tile_ready;
    logic        wr_start;
    logic [31:0] wr_addr;
    logic [15:0] wr_stride;
    logic        wr_bank;
    logic        wr_reading;
    logic        wr_flushed;

    typedef struct packed {
        logic [31:0] addr;
        logic        bank;
        logic [15:0] stride;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t obs_q[$];
    int    obs_rd;
    int    n_checks;
    int    n_fail;
    int    acc_cnt;
    int    done_cnt;
    int    cmp_cnt;
    int    ovf_err;
    int    acc0;
    int    done0;
    int    busy_cnt;
    int    hold_cycles;
    bit    flush_ok;
    bit    start_seen;
    logic  exp_bank;

    tile_flush_scheduler dut (
        .gpu_clk          (gpu_clk),
        .gpu_rst          (gpu_rst),
        .frame_base       (frame_base),
        .frame_stride     (frame_stride),
        .tiles_x          (tiles_x),
        .tiles_y          (tiles_y),
        .frame_start      (frame_start),
        .frame_busy       (frame_busy),
        .frame_done       (frame_done),
        .raster_bank      (raster_bank),
        .raster_tile_valid(raster_tile_valid),
        .raster_tile_ready(raster_tile_ready),
        .wr_start         (wr_start),
        .wr_addr          (wr_addr),
        .wr_stride        (wr_stride),
        .wr_bank          (wr_bank),
        .wr_reading       (wr_reading),
        .wr_flushed       (wr_flushed)
    );

    always #5 gpu_clk = ~gpu_clk;

    assign wr_reading = (busy_cnt != 0) && !gpu_rst;
    assign wr_flushed = !wr_reading && flush_ok;

    // Writer model: reading starts the cycle after wr_start and lasts hold_cycles cycles.
    always begin
        @(negedge gpu_clk);
        start_seen = wr_start && !gpu_rst;
        @(posedge gpu_clk);
        #1;
        if (gpu_rst) begin
            busy_cnt = 0;
        end else if (start_seen) begin
            busy_cnt = hold_cycles;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) cmp_cnt = cmp_cnt + 1;
        end
    end

    always @(negedge gpu_clk) begin
        if (!gpu_rst) begin
            if (wr_start) obs_q.push_back({wr_addr, wr_bank, wr_stride});
            if (frame_done) done_cnt = done_cnt + 1;
            if (raster_tile_valid && raster_tile_ready) begin
                if (acc_cnt - cmp_cnt >= 2) ovf_err = ovf_err + 1;
                acc_cnt = acc_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge gpu_clk);
        #1;
    endtask

    task automatic push_expected(input logic [31:0] base, input logic [15:0] stride,
                                 input int nx, input int ny);
        logic [31:0] step;
        step = {11'h0, stride, 5'h0};
        for (int y = 0; y < ny; y++) begin
            for (int x = 0; x < nx; x++) begin
                exp_q.push_back({base + step * 32'(y) + 32'(x * 64), exp_bank, stride});
                exp_bank = ~exp_bank;
            end
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                               input logic [7:0] nx, input logic [7:0] ny);
        acc0         = acc_cnt;
        done0        = done_cnt;
        frame_base   = base;
        frame_stride = stride;
        tiles_x      = nx;
        tiles_y      = ny;
        frame_start  = 1'b1;
        tick();
        frame_start  = 1'b0;
    endtask

    task automatic wait_done(input int total, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            raster_tile_valid = (acc_cnt - acc0) < total;
            tick();
            if (done_cnt > done0) seen = 1'b1;
        end
        raster_tile_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [53:0] outs;
        gpu_rst = 1'b1;
        repeat (3) tick();
        outs = {frame_busy, frame_done, raster_bank, raster_tile_ready, wr_start, wr_addr,
                wr_stride, wr_bank};
        n_checks++;
        if (outs !== 54'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, need 0", outs);
        end
        gpu_rst = 1'b0;
        repeat (2) tick();
        outs = {frame_busy, frame_done, raster_bank, raster_tile_ready, wr_start, wr_addr,
                wr_stride, wr_bank};
        n_checks++;
        if (outs !== 54'h0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h, need 0", outs);
        end
    endtask

    task automatic test_two_tiles();
        bit    seen;
        xfer_t e;
        xfer_t o;
        hold_cycles = 2;
        flush_ok    = 1'b0;
        push_expected(32'h1000, 16'h400, 2, 1);
        start_frame(32'h1000, 16'h400, 8'd2, 8'd1);
        wait_done(2, 60, seen);
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL t1_done_before_flush: got done, need none");
        end
        flush_ok = 1'b1;
        wait_done(2, 10, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL t1_done_after_flush: got none, need done");
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL t1_xfer: got none, need addr %h", e.addr);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL t1_xfer: got %h/%b/%h, need %h/%b/%h", o.addr, o.bank,
                             o.stride, e.addr, e.bank, e.stride);
                end
            end
        end
    endtask

    task automatic test_two_by_two();
        bit    seen;
        xfer_t e;
        xfer_t o;
        hold_cycles = 3;
        push_expected(32'h1000, 16'h400, 2, 2);
        start_frame(32'h1000, 16'h400, 8'd2, 8'd2);
        wait_done(4, 200, seen);
        repeat (5) tick();
        n_checks++;
        if (done_cnt - done0 != 1) begin
            n_fail++;
            $display("FAIL t2_done_count: got %0d, need 1", done_cnt - done0);
        end
        n_checks++;
        if (obs_q.size() - obs_rd != 4) begin
            n_fail++;
            $display("FAIL t2_start_count: got %0d, need 4", obs_q.size() - obs_rd);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL t2_xfer: got none, need addr %h", e.addr);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL t2_xfer: got %h/%b/%h, need %h/%b/%h", o.addr, o.bank,
                             o.stride, e.addr, e.bank, e.stride);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit    seen;
        bit    was_high;
        bit    found;
        xfer_t e;
        xfer_t o;
        hold_cycles = 600;
        push_expected(32'h0, 16'h100, 3, 1);
        start_frame(32'h0, 16'h100, 8'd3, 8'd1);
        raster_tile_valid = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (acc_cnt - acc0 != 2) begin
            n_fail++;
            $display("FAIL t3_accepts: got %0d, need 2", acc_cnt - acc0);
        end
        n_checks++;
        if (raster_tile_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_ready_low: got %b, need 0", raster_tile_ready);
        end
        was_high = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge gpu_clk);
            if (wr_reading) was_high = 1'b1;
            else if (was_high) found = 1'b1;
        end
        n_checks++;
        if (!found || raster_tile_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_ready_before_drain: got found=%b ready=%b, need 1/0", found,
                     raster_tile_ready);
        end
        @(negedge gpu_clk);
        n_checks++;
        if (raster_tile_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_ready_rise: got %b, need 1", raster_tile_ready);
        end
        wait_done(3, 3000, seen);
        n_checks++;
        if (!seen || ovf_err != 0) begin
            n_fail++;
            $display("FAIL t3_done_no_overwrite: got done=%b overwrites=%0d, need 1/0", seen,
                     ovf_err);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL t3_xfer: got none, need addr %h", e.addr);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL t3_xfer: got %h/%b/%h, need %h/%b/%h", o.addr, o.bank,
                             o.stride, e.addr, e.bank, e.stride);
                end
            end
        end
    endtask

    task automatic test_zero_tiles();
        int obs0;
        obs0 = obs_q.size();
        raster_tile_valid = 1'b1;
        start_frame(32'h5000, 16'h200, 8'd0, 8'd5);
        @(negedge gpu_clk);
        n_checks++;
        if (frame_done !== 1'b1 || raster_tile_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_done_pulse: got done=%b ready=%b, need 1/0", frame_done,
                     raster_tile_ready);
        end
        @(negedge gpu_clk);
        n_checks++;
        if (frame_done !== 1'b0 || frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_idle_after: got done=%b busy=%b, need 0/0", frame_done,
                     frame_busy);
        end
        raster_tile_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != obs0 || acc_cnt != acc0) begin
            n_fail++;
            $display("FAIL t4_no_activity: got starts=%0d accepts=%0d, need 0/0",
                     obs_q.size() - obs0, acc_cnt - acc0);
        end
    endtask

    task automatic test_ignore_busy();
        bit    seen;
        xfer_t e;
        xfer_t o;
        hold_cycles = 20;
        push_expected(32'h2000, 16'h80, 1, 1);
        start_frame(32'h2000, 16'h80, 8'd1, 8'd1);
        raster_tile_valid = 1'b1;
        repeat (3) tick();
        frame_base   = 32'hDEAD0000;
        frame_stride = 16'h1234;
        tiles_x      = 8'd3;
        tiles_y      = 8'd3;
        frame_start  = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (acc_cnt - acc0 != 1 || wr_stride !== 16'h80 || frame_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_ignored: got acc=%0d stride=%h busy=%b, need 1/0080/1",
                     acc_cnt - acc0, wr_stride, frame_busy);
        end
        wait_done(1, 200, seen);
        repeat (5) tick();
        n_checks++;
        if (!seen || done_cnt - done0 != 1 || frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_single_done: got done=%0d busy=%b, need 1/0", done_cnt - done0,
                     frame_busy);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL t5_xfer: got none, need addr %h", e.addr);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL t5_xfer: got %h/%b/%h, need %h/%b/%h", o.addr, o.bank,
                             o.stride, e.addr, e.bank, e.stride);
                end
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        bit          seen;
        bit          in_wait;
        logic [53:0] outs;
        xfer_t       e;
        xfer_t       o;
        hold_cycles = 2;
        push_expected(32'hFFFFFFC0, 16'h40, 2, 1);
        start_frame(32'hFFFFFFC0, 16'h40, 8'd2, 8'd1);
        wait_done(2, 100, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL t6_wrap_done: got none, need done");
        end
        hold_cycles = 600;
        exp_q.push_back({32'h3000, exp_bank, 16'h100});
        start_frame(32'h3000, 16'h100, 8'd2, 8'd1);
        in_wait = 1'b0;
        for (int i = 0; i < 50 && !in_wait; i++) begin
            raster_tile_valid = (acc_cnt - acc0) < 2;
            tick();
            in_wait = wr_reading;
        end
        raster_tile_valid = 1'b0;
        @(negedge gpu_clk);
        #1;
        gpu_rst = 1'b1;
        #1;
        outs = {frame_busy, frame_done, raster_bank, raster_tile_ready, wr_start, wr_addr,
                wr_stride, wr_bank};
        n_checks++;
        if (!in_wait || outs !== 54'h0) begin
            n_fail++;
            $display("FAIL t6_reset_mid_wait: got in_wait=%b outs=%h, need 1/0", in_wait, outs);
        end
        repeat (2) tick();
        gpu_rst  = 1'b0;
        exp_bank = 1'b0;
        repeat (3) tick();
        outs = {frame_busy, frame_done, raster_bank, raster_tile_ready, wr_start, wr_addr,
                wr_stride, wr_bank};
        n_checks++;
        if (outs !== 54'h0) begin
            n_fail++;
            $display("FAIL t6_after_reset: got %h, need 0", outs);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL t6_xfer: got none, need addr %h", e.addr);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL t6_xfer: got %h/%b/%h, need %h/%b/%h", o.addr, o.bank,
                             o.stride, e.addr, e.bank, e.stride);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL extra_starts: got %0d, need 0", obs_q.size() - obs_rd);
        end
    endtask

    initial begin
        gpu_rst           = 1'b1;
        frame_base        = 32'h0;
        frame_stride      = 16'h0;
        tiles_x           = 8'h0;
        tiles_y           = 8'h0;
        frame_start       = 1'b0;
        raster_tile_valid = 1'b0;
        hold_cycles       = 2;
        flush_ok          = 1'b1;
        exp_bank          = 1'b0;
        n_checks          = 0;
        n_fail            = 0;
        obs_rd            = 0;

        test_reset();
        test_two_tiles();
        test_two_by_two();
        test_backpressure();
        test_zero_tiles();
        test_ignore_busy();
        test_wrap_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
